// File: rtl/led_matrix_scanner.sv
// Row-at-a-time scanner for an 8x8 matrix of 4-bit intensities: loads one row from the frame RAM
// into a line buffer, then shows it with 16-level PWM, followed by a short all-dark blanking gap.
module led_matrix_scanner #(
   parameter int unsigned TICK_DIV       = 64,
   parameter int unsigned BLANK_CYC      = 4,
   parameter bit          ROW_ACTIVE_LOW = 1'b0,
   parameter bit          COL_ACTIVE_LOW = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [3:0] led_data,
   output logic [7:0] rd_row,
   output logic [7:0] rd_col,
   output logic       rd_active,
   output logic [7:0] row_sel,
   output logic [7:0] col_drv,
   output logic       frame_start
);

   localparam int unsigned CNT_MAX = (TICK_DIV > BLANK_CYC) ? TICK_DIV : BLANK_CYC;
   localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CW-1:0] TICK_LAST  = CW'(TICK_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [3:0]    SLOT_LAST  = 4'd14;
   localparam logic [2:0]    COL_LAST   = 3'd7;
   localparam logic [7:0]    ROW_OFF    = {8{ROW_ACTIVE_LOW}};
   localparam logic [7:0]    COL_OFF    = {8{COL_ACTIVE_LOW}};

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DISPLAY,
      S_BLANK
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [2:0]      row;
   logic [2:0]      col;
   logic [3:0]      slot;
   logic [CW-1:0]   cnt;
   logic [3:0]      line [8];
   logic [7:0]      row_sel_nxt;
   logic [7:0]      col_drv_nxt;
   logic            tick_done;
   logic            blank_done;

   assign tick_done  = (cnt == TICK_LAST);
   assign blank_done = (cnt == BLANK_LAST);

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------- next-state logic
   always_comb begin
      state_nxt = state;
      if (!enable) begin
         state_nxt = S_IDLE;
      end else begin
         unique case (state)
            S_IDLE:    state_nxt = S_LOAD;
            S_LOAD:    if (col == COL_LAST) state_nxt = S_DISPLAY;
            S_DISPLAY: if (tick_done && slot == SLOT_LAST) state_nxt = S_BLANK;
            S_BLANK:   if (blank_done) state_nxt = S_LOAD;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- row/col/slot/tick counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row  <= '0;
         col  <= '0;
         slot <= '0;
         cnt  <= '0;
      end else if (!enable) begin
         row  <= '0;
         col  <= '0;
         slot <= '0;
         cnt  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               row  <= '0;
               col  <= '0;
               slot <= '0;
               cnt  <= '0;
            end
            S_LOAD: begin
               col  <= col + 3'd1;
               slot <= '0;
               cnt  <= '0;
            end
            S_DISPLAY: begin
               if (tick_done) begin
                  cnt  <= '0;
                  slot <= (slot == SLOT_LAST) ? 4'd0 : slot + 4'd1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_BLANK: begin
               if (blank_done) begin
                  cnt <= '0;
                  row <= row + 3'd1;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: begin
               row  <= '0;
               col  <= '0;
               slot <= '0;
               cnt  <= '0;
            end
         endcase
      end
   end

   // Only LOAD writes the line buffer, so RAM updates never tear a row mid-display
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < 8; i++) begin
            line[i] <= '0;
         end
      end else if (enable && state == S_LOAD) begin
         line[col] <= led_data;
      end
   end

   // ---------------------------------------------------------------- output decode
   always_comb begin
      rd_row      = '0;
      rd_col      = '0;
      rd_active   = 1'b0;
      frame_start = 1'b0;
      row_sel_nxt = '0;
      col_drv_nxt = '0;
      unique case (state)
         S_LOAD: begin
            rd_row      = 8'd1 << row;
            rd_col      = 8'd1 << col;
            rd_active   = 1'b1;
            frame_start = (row == 3'd0) && (col == 3'd0);
         end
         S_DISPLAY: begin
            row_sel_nxt = 8'd1 << row;
            for (int unsigned c = 0; c < 8; c++) begin
               col_drv_nxt[c] = (line[c] > slot);
            end
         end
         default: begin
            row_sel_nxt = '0;
            col_drv_nxt = '0;
         end
      endcase
   end

   // Pin registers: drive levels lag the state by one cycle, with polarity folded in here
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_sel <= ROW_OFF;
         col_drv <= COL_OFF;
      end else begin
         row_sel <= row_sel_nxt ^ ROW_OFF;
         col_drv <= col_drv_nxt ^ COL_OFF;
      end
   end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: load-phase vector table, per-row-visit PWM scoreboard,
// frame wrap timing, enable drop/restart and active-low pin polarity.
module tb_led_matrix_scanner;

   localparam int TD    = 2;
   localparam int BC    = 4;
   localparam int LIT   = 15 * TD;
   localparam int RPER  = 8 + 15 * TD + BC;
   localparam int FRAME = 8 * RPER;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic [3:0] led_data, led_data2;
   logic [7:0] rd_row, rd_col, row_sel, col_drv;
   logic       rd_active, frame_start;
   logic [7:0] rd_row2, rd_col2, row_sel2, col_drv2;
   logic       rd_active2, frame_start2;

   logic [3:0] mem [8][8];
   logic [3:0] new0 [8];

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en;

   always #5 clk = ~clk;

   function automatic int oh2i(input logic [7:0] v);
      int idx = 0;
      for (int i = 0; i < 8; i++) if (v[i]) idx = i;
      return idx;
   endfunction

   function automatic logic [3:0] lvl1(input int r, input int c);
      return (r == 0) ? 4'(c) : 4'((r * 3 + c * 5 + 1) % 16);
   endfunction

   assign led_data  = mem[oh2i(rd_row)][oh2i(rd_col)];
   assign led_data2 = mem[oh2i(rd_row2)][oh2i(rd_col2)];

   led_matrix_scanner #(
      .TICK_DIV(TD), .BLANK_CYC(BC), .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .led_data(led_data),
      .rd_row(rd_row), .rd_col(rd_col), .rd_active(rd_active),
      .row_sel(row_sel), .col_drv(col_drv), .frame_start(frame_start)
   );

   led_matrix_scanner #(
      .TICK_DIV(TD), .BLANK_CYC(BC), .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)
   ) dut_inv (
      .clk(clk), .rst_n(rst_n), .enable(enable), .led_data(led_data2),
      .rd_row(rd_row2), .rd_col(rd_col2), .rd_active(rd_active2),
      .row_sel(row_sel2), .col_drv(col_drv2), .frame_start(frame_start2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- load-phase vector table
   typedef struct packed {
      logic [7:0] rd_row;
      logic [7:0] rd_col;
      logic       rd_active;
      logic       fs;
      logic [7:0] row_sel;
      logic [7:0] col_drv;
      logic [7:0] row_sel_inv;
      logic [7:0] col_drv_inv;
   } vec_t;

   vec_t tbl [10];

   task automatic run_table(input string tag);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("%s[%0d].rd_row", tag, i),      rd_row,      tbl[i].rd_row);
         check($sformatf("%s[%0d].rd_col", tag, i),      rd_col,      tbl[i].rd_col);
         check($sformatf("%s[%0d].rd_active", tag, i),   rd_active,   tbl[i].rd_active);
         check($sformatf("%s[%0d].frame_start", tag, i), frame_start, tbl[i].fs);
         check($sformatf("%s[%0d].row_sel", tag, i),     row_sel,     tbl[i].row_sel);
         check($sformatf("%s[%0d].col_drv", tag, i),     col_drv,     tbl[i].col_drv);
         check($sformatf("%s[%0d].row_sel_inv", tag, i), row_sel2,    tbl[i].row_sel_inv);
         check($sformatf("%s[%0d].col_drv_inv", tag, i), col_drv2,    tbl[i].col_drv_inv);
      end
   endtask

   // ---------------------------------------------------------------- row-visit scoreboard
   typedef struct packed {
      logic [7:0]      rs;
      logic [7:0][7:0] cnt;
   } visit_t;

   visit_t sb [$];

   initial begin
      int         cyc = 0;
      bit         in_visit = 0;
      bit         have_prev = 0;
      bit         chk_gap = 0;
      int         gap = 0, leak = 0, len = 0, vis_gap = 0, vis_leak = 0, rs_chg = 0;
      int         fs_len = 0, last_fs = 0;
      bit         fs_valid = 0;
      int         obs [8];
      logic [7:0] cur_rs = '0;
      visit_t     exp_v;
      forever begin
         @(negedge clk);
         cyc++;
         if (!mon_en) begin
            in_visit = 0; have_prev = 0; gap = 0; leak = 0; fs_valid = 0; fs_len = 0;
         end else begin
            if (frame_start) begin
               if (fs_len == 0) begin
                  if (fs_valid) check("frame_start_interval", cyc - last_fs, FRAME);
                  last_fs  = cyc;
                  fs_valid = 1;
               end
               fs_len++;
            end else if (fs_len != 0) begin
               check("frame_start_width", fs_len, 1);
               fs_len = 0;
            end
            if (row_sel != 8'h00) begin
               if (!in_visit) begin
                  in_visit = 1; cur_rs = row_sel; len = 0; rs_chg = 0;
                  vis_gap = gap; vis_leak = leak; chk_gap = have_prev;
                  for (int c = 0; c < 8; c++) obs[c] = 0;
               end
               len++;
               if (row_sel != cur_rs) rs_chg++;
               for (int c = 0; c < 8; c++) obs[c] += int'(col_drv[c]);
            end else begin
               if (in_visit) begin
                  if (sb.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL sb_underflow: actual visit row_sel %0h, required no visit", cur_rs);
                  end else begin
                     exp_v = sb.pop_front();
                     check("visit_row_sel", cur_rs, exp_v.rs);
                     check("visit_row_stable", rs_chg, 0);
                     check("visit_lit_len", len, LIT);
                     for (int c = 0; c < 8; c++)
                        check($sformatf("visit_r%0h_col%0d", exp_v.rs, c), obs[c], exp_v.cnt[c]);
                     if (chk_gap) check("visit_dark_gap", vis_gap, RPER - LIT);
                     check("visit_col_leak", vis_leak, 0);
                  end
                  in_visit = 0; have_prev = 1; gap = 0; leak = 0;
               end
               gap++;
               if (col_drv != 8'h00) leak++;
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: actual timeout, required test completion");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- main sequence
   initial begin
      visit_t v;
      for (int i = 0; i < 8; i++)
         tbl[i] = '{8'h01, 8'h01 << i, 1'b1, 1'(i == 0), 8'h00, 8'h00, 8'hFF, 8'hFF};
      tbl[8] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF, 8'hFF};
      tbl[9] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h01, 8'hFE, 8'hFE, 8'h01};

      new0 = '{4'd0, 4'd1, 4'd7, 4'd15, 4'd3, 4'd8, 4'd14, 4'd2};
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++) mem[r][c] = lvl1(r, c);

      rst_n  = 1'b0;
      enable = 1'b1;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      check("rst.rd_row", rd_row, 8'h00);
      check("rst.rd_col", rd_col, 8'h00);
      check("rst.rd_active", rd_active, 1'b0);
      check("rst.frame_start", frame_start, 1'b0);
      check("rst.row_sel", row_sel, 8'h00);
      check("rst.col_drv", col_drv, 8'h00);
      check("rst.row_sel_inv", row_sel2, 8'hFF);
      check("rst.col_drv_inv", col_drv2, 8'hFF);

      // Two frames of expected row visits; row 0 of frame 2 sees the rewritten RAM row
      for (int f = 0; f < 2; f++) begin
         for (int r = 0; r < 8; r++) begin
            v.rs = 8'h01 << r;
            for (int c = 0; c < 8; c++)
               v.cnt[c] = 8'(TD * int'((f == 1 && r == 0) ? new0[c] : lvl1(r, c)));
            sb.push_back(v);
         end
      end

      rst_n = 1'b1;
      run_table("load");
      for (int c = 0; c < 8; c++) mem[0][c] = new0[c];

      for (int i = 0; i < 3 * FRAME; i++) begin
         @(negedge clk);
         if (sb.size() == 0) break;
      end
      check("sb_drained", sb.size(), 0);
      mon_en = 1'b0;

      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         if (row_sel == 8'h08) break;
      end
      check("reach_row3", row_sel, 8'h08);
      repeat (5) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("drop.rd_active", rd_active, 1'b0);
      check("drop.frame_start", frame_start, 1'b0);
      check("drop.row_sel_lag", row_sel, 8'h08);
      @(negedge clk);
      check("drop.row_sel", row_sel, 8'h00);
      check("drop.col_drv", col_drv, 8'h00);
      check("drop.row_sel_inv", row_sel2, 8'hFF);
      check("drop.col_drv_inv", col_drv2, 8'hFF);
      repeat (3) @(negedge clk);
      check("idle.rd_row", rd_row, 8'h00);
      check("idle.rd_col", rd_col, 8'h00);
      check("idle.row_sel", row_sel, 8'h00);
      check("idle.frame_start", frame_start, 1'b0);

      enable = 1'b1;
      run_table("reload");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
